// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Operand forwarding and hazard detection for the ID stage. Each ID source
// port picks its operand from the register file, from one of FW_DEPTH
// in-flight pipeline stages (the youngest match wins), or from the
// long-latency unit's writeback bus. A per-register scoreboard tracks
// results still owed by the variable-latency unit (div/mul/long loads).
// The block raises a stall on a load-use, RAW or WAW hazard and counts
// stalled cycles.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   id_valid_i       ID holds a valid instruction
//   id_rs_addr_i     packed source addresses, port r at [r*ADDR_W +: ADDR_W]
//   id_rs_used_i     per-port "source is actually read"
//   id_rd_addr_i     ID destination register
//   id_regwrite_i    ID instruction writes rd
//   id_long_i        ID instruction issues to the long-latency unit
//   stg_regwrite_i   stage k (bit k-1) writes its rd
//   stg_rd_addr_i    packed stage destinations, stage k at [(k-1)*ADDR_W]
//   stg_data_rdy_i   stage k result can be forwarded (0 = load in flight)
//   lo_wb_i          long unit writes back this cycle
//   lo_wb_addr_i     long unit writeback destination
//   fw_sel_o         per-port select: 0 regfile, k stage k, FW_DEPTH+1 long wb
//   stall_o          hold ID/IF and inject a bubble
//   sb_pending_o     scoreboard: register still owed by the long unit
//   stall_cnt_o      saturating count of stalled valid cycles
//   err_o            sticky: writeback to a register that was not pending
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int NUM_READ = 2,
    parameter int FW_DEPTH = 2,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int SEL_W    = $clog2(FW_DEPTH + 2),
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid_i,
    input  logic [NUM_READ*ADDR_W-1:0]   id_rs_addr_i,
    input  logic [NUM_READ-1:0]          id_rs_used_i,
    input  logic [ADDR_W-1:0]            id_rd_addr_i,
    input  logic                         id_regwrite_i,
    input  logic                         id_long_i,
    input  logic [FW_DEPTH-1:0]          stg_regwrite_i,
    input  logic [FW_DEPTH*ADDR_W-1:0]   stg_rd_addr_i,
    input  logic [FW_DEPTH-1:0]          stg_data_rdy_i,
    input  logic                         lo_wb_i,
    input  logic [ADDR_W-1:0]            lo_wb_addr_i,
    output logic [NUM_READ*SEL_W-1:0]    fw_sel_o,
    output logic                         stall_o,
    output logic [NUM_REGS-1:0]          sb_pending_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic                         err_o
);

    logic [NUM_REGS-1:0]       pending_q, pending_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic                      err_q, err_d;

    logic [NUM_READ*SEL_W-1:0] fwSel;
    logic [SEL_W-1:0]          portSel;
    logic                      portHit;
    logic                      portRdy;
    logic [ADDR_W-1:0]         portRs;
    logic                      loadUse;
    logic                      rawHazard;
    logic                      wawHazard;
    logic                      stallInt;
    logic                      issueLong;

    // Per-port forwarding select plus load-use and RAW detection. Stages are
    // scanned from oldest to youngest so a younger match overwrites an older
    // one, which gives the youngest writer priority. The long-unit writeback
    // bus is only used when no pipeline stage claims the register, and it
    // also satisfies a pending scoreboard entry in its own writeback cycle.
    always_comb begin
        fwSel     = '0;
        portSel   = '0;
        portHit   = 1'b0;
        portRdy   = 1'b1;
        portRs    = '0;
        loadUse   = 1'b0;
        rawHazard = 1'b0;
        for (int r = 0; r < NUM_READ; r++) begin
            portSel = '0;
            portHit = 1'b0;
            portRdy = 1'b1;
            portRs  = id_rs_addr_i[r*ADDR_W +: ADDR_W];
            if (id_rs_used_i[r] && (portRs != '0)) begin
                for (int k = FW_DEPTH; k >= 1; k--) begin
                    if (stg_regwrite_i[k-1] &&
                        (stg_rd_addr_i[(k-1)*ADDR_W +: ADDR_W] == portRs)) begin
                        portSel = SEL_W'(k);
                        portHit = 1'b1;
                        portRdy = stg_data_rdy_i[k-1];
                    end
                end
                if (!portHit && lo_wb_i && (lo_wb_addr_i == portRs)) begin
                    portSel = SEL_W'(FW_DEPTH + 1);
                end
                if (portHit && !portRdy) begin
                    loadUse = 1'b1;
                end
                if (pending_q[portRs] && !(lo_wb_i && (lo_wb_addr_i == portRs))) begin
                    rawHazard = 1'b1;
                end
            end
            fwSel[r*SEL_W +: SEL_W] = portSel;
        end
    end

    // A second write to a register the long unit still owes must wait,
    // unless that result is retiring in this very cycle.
    always_comb begin
        wawHazard = id_regwrite_i && (id_rd_addr_i != '0) && pending_q[id_rd_addr_i]
                    && !(lo_wb_i && (lo_wb_addr_i == id_rd_addr_i));
        stallInt  = id_valid_i && (loadUse || rawHazard || wawHazard);
        issueLong = id_valid_i && id_long_i && id_regwrite_i && !stallInt
                    && (id_rd_addr_i != '0);
    end

    // Scoreboard, error flag and stall counter next state. The set is applied
    // after the clear so an issue and a writeback to the same register in one
    // cycle leave the bit pending for the new operation. A writeback nobody
    // was waiting for (including x0) changes nothing but flags an error.
    always_comb begin
        pending_d   = pending_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        if (lo_wb_i) begin
            if ((lo_wb_addr_i == '0) || !pending_q[lo_wb_addr_i]) begin
                err_d = 1'b1;
            end else begin
                pending_d[lo_wb_addr_i] = 1'b0;
            end
        end
        if (issueLong) begin
            pending_d[id_rd_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (stallInt && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops every outstanding long operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign fw_sel_o     = fwSel;
    assign stall_o      = stallInt;
    assign sb_pending_o = pending_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
//
// Directed bench for fwd_hazard_scoreboard (default parameters). Each
// stimulus cycle drives the inputs just after the rising edge and queues the
// hand-computed outputs expected for that cycle; a monitor on the falling
// edge pops the queue and compares every output.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

    localparam int NUM_READ = 2;
    localparam int FW_DEPTH = 2;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 16;

    logic                       clk;
    logic                       rst;
    logic                       id_valid_i;
    logic [NUM_READ*ADDR_W-1:0] id_rs_addr_i;
    logic [NUM_READ-1:0]        id_rs_used_i;
    logic [ADDR_W-1:0]          id_rd_addr_i;
    logic                       id_regwrite_i;
    logic                       id_long_i;
    logic [FW_DEPTH-1:0]        stg_regwrite_i;
    logic [FW_DEPTH*ADDR_W-1:0] stg_rd_addr_i;
    logic [FW_DEPTH-1:0]        stg_data_rdy_i;
    logic                       lo_wb_i;
    logic [ADDR_W-1:0]          lo_wb_addr_i;
    logic [NUM_READ*SEL_W-1:0]  fw_sel_o;
    logic                       stall_o;
    logic [NUM_REGS-1:0]        sb_pending_o;
    logic [CNT_W-1:0]           stall_cnt_o;
    logic                       err_o;

    typedef struct packed {
        logic       rst;
        logic       idValid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] used;
        logic [4:0] rd;
        logic       regwrite;
        logic       isLong;
        logic [1:0] stgRegwrite;
        logic [4:0] stgRd1;
        logic [4:0] stgRd2;
        logic [1:0] stgRdy;
        logic       loWb;
        logic [4:0] loWbAddr;
    } vecT;

    typedef struct packed {
        logic [3:0]  sel;
        logic        stall;
        logic [31:0] pend;
        logic [15:0] cnt;
        logic        err;
    } expT;

    expT   expQ[$];
    string nameQ[$];
    expT   monExp;
    string monName;
    int    compared   = 0;
    int    mismatched = 0;
    vecT   v;

    fwd_hazard_scoreboard #(
        .NUM_READ (NUM_READ),
        .FW_DEPTH (FW_DEPTH),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_rs_addr_i   (id_rs_addr_i),
        .id_rs_used_i   (id_rs_used_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_long_i      (id_long_i),
        .stg_regwrite_i (stg_regwrite_i),
        .stg_rd_addr_i  (stg_rd_addr_i),
        .stg_data_rdy_i (stg_data_rdy_i),
        .lo_wb_i        (lo_wb_i),
        .lo_wb_addr_i   (lo_wb_addr_i),
        .fw_sel_o       (fw_sel_o),
        .stall_o        (stall_o),
        .sb_pending_o   (sb_pending_o),
        .stall_cnt_o    (stall_cnt_o),
        .err_o          (err_o)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic applyStimulus(input vecT s);
        @(posedge clk);
        #1;
        rst            = s.rst;
        id_valid_i     = s.idValid;
        id_rs_addr_i   = {s.rs2, s.rs1};
        id_rs_used_i   = s.used;
        id_rd_addr_i   = s.rd;
        id_regwrite_i  = s.regwrite;
        id_long_i      = s.isLong;
        stg_regwrite_i = s.stgRegwrite;
        stg_rd_addr_i  = {s.stgRd2, s.stgRd1};
        stg_data_rdy_i = s.stgRdy;
        lo_wb_i        = s.loWb;
        lo_wb_addr_i   = s.loWbAddr;
    endtask

    // Queue the outputs expected for the cycle just driven.
    task automatic expectOutput(input string name, input logic [3:0] sel,
                                input logic stall, input logic [31:0] pend,
                                input logic [15:0] cnt, input logic err);
        expT e;
        e.sel   = sel;
        e.stall = stall;
        e.pend  = pend;
        e.cnt   = cnt;
        e.err   = err;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic cmpField(input string name, input string field,
                            input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input expT e);
        cmpField(name, "fw_sel",  32'(fw_sel_o),     32'(e.sel));
        cmpField(name, "stall",   32'(stall_o),      32'(e.stall));
        cmpField(name, "pending", 32'(sb_pending_o), e.pend);
        cmpField(name, "cnt",     32'(stall_cnt_o),  32'(e.cnt));
        cmpField(name, "err",     32'(err_o),        32'(e.err));
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            checkOutput(monName, monExp);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #3000000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vectors; fw_sel is {port1 sel, port0 sel}.
    initial begin
        rst = 1'b1;
        id_valid_i = 1'b0; id_rs_addr_i = '0; id_rs_used_i = '0;
        id_rd_addr_i = '0; id_regwrite_i = 1'b0; id_long_i = 1'b0;
        stg_regwrite_i = '0; stg_rd_addr_i = '0; stg_data_rdy_i = '0;
        lo_wb_i = 1'b0; lo_wb_addr_i = '0;

        v = '0; v.rst = 1'b1;
        applyStimulus(v); expectOutput("reset", 4'b0000, 0, 32'h0, 16'd0, 0);

        v = '0; v.idValid = 1; v.rs1 = 5; v.rs2 = 6; v.used = 2'b11;
        applyStimulus(v); expectOutput("nohaz", 4'b0000, 0, 32'h0, 16'd0, 0);

        v.stgRegwrite = 2'b11; v.stgRd1 = 5; v.stgRd2 = 5; v.stgRdy = 2'b11;
        applyStimulus(v); expectOutput("prio", 4'b0001, 0, 32'h0, 16'd0, 0);

        v.stgRegwrite = 2'b10;
        applyStimulus(v); expectOutput("prio2", 4'b0010, 0, 32'h0, 16'd0, 0);

        v = '0; v.idValid = 1; v.used = 2'b11; v.stgRegwrite = 2'b11; v.stgRdy = 2'b11;
        applyStimulus(v); expectOutput("rs0", 4'b0000, 0, 32'h0, 16'd0, 0);

        v = '0; v.idValid = 1; v.rs1 = 5; v.rs2 = 7; v.used = 2'b11;
        v.stgRegwrite = 2'b01; v.stgRd1 = 7; v.stgRdy = 2'b00;
        applyStimulus(v); expectOutput("lduse", 4'b0100, 1, 32'h0, 16'd0, 0);

        v.stgRegwrite = 2'b10; v.stgRd1 = 0; v.stgRd2 = 7; v.stgRdy = 2'b10;
        applyStimulus(v); expectOutput("lduse2", 4'b1000, 0, 32'h0, 16'd1, 0);

        v = '0; v.idValid = 1; v.rd = 9; v.regwrite = 1; v.isLong = 1;
        applyStimulus(v); expectOutput("issue9", 4'b0000, 0, 32'h0, 16'd1, 0);

        v = '0; v.idValid = 1; v.rs1 = 9; v.used = 2'b01;
        applyStimulus(v); expectOutput("raw1", 4'b0000, 1, 32'h200, 16'd1, 0);
        applyStimulus(v); expectOutput("raw2", 4'b0000, 1, 32'h200, 16'd2, 0);

        v.loWb = 1; v.loWbAddr = 9;
        applyStimulus(v); expectOutput("rawwb", 4'b0011, 0, 32'h200, 16'd3, 0);

        v.loWb = 0; v.loWbAddr = 0;
        applyStimulus(v); expectOutput("cleared", 4'b0000, 0, 32'h0, 16'd3, 0);

        v = '0; v.idValid = 1; v.rd = 9; v.regwrite = 1; v.isLong = 1;
        applyStimulus(v); expectOutput("issue9b", 4'b0000, 0, 32'h0, 16'd3, 0);

        v.rd = 4;
        applyStimulus(v); expectOutput("issue4", 4'b0000, 0, 32'h200, 16'd3, 0);

        v = '0; v.idValid = 1; v.rd = 9; v.regwrite = 1;
        applyStimulus(v); expectOutput("waw", 4'b0000, 1, 32'h210, 16'd3, 0);

        v = '0; v.idValid = 1; v.rd = 4; v.regwrite = 1; v.isLong = 1;
        v.loWb = 1; v.loWbAddr = 4;
        applyStimulus(v); expectOutput("setclr4", 4'b0000, 0, 32'h210, 16'd4, 0);

        v = '0;
        applyStimulus(v); expectOutput("after4", 4'b0000, 0, 32'h210, 16'd4, 0);

        v = '0; v.loWb = 1; v.loWbAddr = 12;
        applyStimulus(v); expectOutput("wb12", 4'b0000, 0, 32'h210, 16'd4, 0);

        v = '0;
        applyStimulus(v); expectOutput("errset", 4'b0000, 0, 32'h210, 16'd4, 1);

        v = '0; v.rs1 = 9; v.used = 2'b01;
        applyStimulus(v); expectOutput("novalid", 4'b0000, 0, 32'h210, 16'd4, 1);

        v = '0; v.rst = 1;
        applyStimulus(v); expectOutput("midrst", 4'b0000, 0, 32'h0, 16'd0, 0);

        v = '0; v.loWb = 1; v.loWbAddr = 4;
        applyStimulus(v); expectOutput("postrst", 4'b0000, 0, 32'h0, 16'd0, 0);

        v = '0;
        applyStimulus(v); expectOutput("staleErr", 4'b0000, 0, 32'h0, 16'd0, 1);

        v = '0; v.idValid = 1; v.rs1 = 7; v.used = 2'b01;
        v.stgRegwrite = 2'b01; v.stgRd1 = 7; v.stgRdy = 2'b00;
        applyStimulus(v); expectOutput("satStart", 4'b0001, 1, 32'h0, 16'd0, 1);
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(v);
        end
        applyStimulus(v); expectOutput("sat", 4'b0001, 1, 32'h0, 16'hFFFF, 1);
        applyStimulus(v); expectOutput("satHold", 4'b0001, 1, 32'h0, 16'hFFFF, 1);

        v = '0;
        applyStimulus(v); expectOutput("satIdle", 4'b0000, 0, 32'h0, 16'hFFFF, 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the 2-stage forwarding unit.
- Generalises forwarding to NUM_READ source ports over FW_DEPTH in-flight pipeline stages, with youngest-match priority.
- Adds a per-register scoreboard for variable-latency units (div/mul/long loads), plus load-use/RAW/WAW stall generation and a stall performance counter.
- Sits beside the ID stage; drives operand muxes and the pipeline stall/bubble logic.

Parameters:
- NUM_READ, 2, number of ID source-register read ports.
- FW_DEPTH, 2, number of forwarding stages; stage 1 is youngest (EX), stage FW_DEPTH is oldest.
- NUM_REGS, 32, architectural register count; x0 is hardwired zero.
- ADDR_W, $clog2(NUM_REGS), register address width (derived).
- SEL_W, $clog2(FW_DEPTH+2), forward-select width (derived).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs_addr_i  in  NUM_READ*ADDR_W  source addresses; port r is in bits [r*ADDR_W +: ADDR_W].
- id_rs_used_i  in  NUM_READ  port r is actually read.
- id_rd_addr_i  in  ADDR_W  ID destination.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_long_i  in  1  ID instruction issues to the long-latency unit.
- stg_regwrite_i  in  FW_DEPTH  stage k (bit k-1) writes rd.
- stg_rd_addr_i  in  FW_DEPTH*ADDR_W  stage k rd.
- stg_data_rdy_i  in  FW_DEPTH  stage k result is available for forwarding (0 = load still in flight).
- lo_wb_i  in  1  long unit writing back this cycle.
- lo_wb_addr_i  in  ADDR_W  long unit writeback rd.
- fw_sel_o  out  NUM_READ*SEL_W  per-port select: 0 = regfile, k = stage k, FW_DEPTH+1 = long-unit writeback.
- stall_o  out  1  hold ID/IF, inject bubble.
- sb_pending_o  out  NUM_REGS  scoreboard vector.
- stall_cnt_o  out  CNT_W  saturating count of stalled valid cycles.
- err_o  out  1  sticky: writeback to a non-pending register.

Behaviour:
- Reset (async, rst=1): sb_pending_o=0, stall_cnt_o=0, err_o=0. All combinational outputs then follow their inputs.
- Forwarding (combinational, zero latency), per port r, only when id_rs_used_i[r]=1 and the address is not 0:
  - Candidate stage k requires stg_regwrite_i[k]=1, rd != 0, and rd == rs.
  - Youngest candidate wins (k=1 highest priority).
  - If there is no stage match and lo_wb_i=1 with lo_wb_addr_i==rs, sel = FW_DEPTH+1.
  - Otherwise sel = 0. Unused ports and rs=0 always give sel 0.
- Stall (combinational), asserted only when id_valid_i=1 and any of:
  - (a) Load-use: for some used port, the winning stage k has stg_data_rdy_i[k]=0.
  - (b) RAW: a used rs has sb_pending_o[rs]=1 and is not satisfied this cycle by a lo_wb_i forward.
  - (c) WAW: id_regwrite_i=1, id_rd_addr_i != 0, and sb_pending_o[rd]=1 with no same-cycle lo_wb_i to rd.
- Scoreboard update (registered, on clk):
  - Set: id_valid_i & id_long_i & id_regwrite_i & !stall_o & rd != 0 sets bit rd.
  - Clear: lo_wb_i clears bit lo_wb_addr_i.
  - Same cycle, same address: set wins, so the bit stays 1.
  - Bit 0 is never set.
  - lo_wb_i to a non-pending address, or to x0: no state change; err_o sets and holds until reset.
- Visibility timing: a pending bit is visible on sb_pending_o the cycle after issue. A register written back in cycle N reads as not pending in cycle N+1. In cycle N itself the result is forwarded via sel FW_DEPTH+1, so no stall.
- Counter: increments when id_valid_i & stall_o, and saturates at all-ones.
- Reset mid-operation: scoreboard clears immediately. Any later lo_wb_i for an operation issued before reset raises err_o.

Test Plan:
- No hazard: rs1=5, rs2=6, no stage matches → fw_sel 0/0, stall_o=0, stall_cnt_o=0.
- Priority: stage1 rd=5 and stage2 rd=5, both regwrite and rdy; rs1=5 → sel1=1. Drop stage1 regwrite → sel1=2. rs=0 with stage1 rd=0 → sel 0.
- Load-use: stage1 rd=7, rdy=0, rs2=7 → stall_o=1 and stall_cnt_o increments by 1. Next cycle (rdy=1 at stage2) → sel2=2, stall_o=0.
- Scoreboard RAW: issue long op rd=9 → sb_pending_o[9]=1 next cycle. Following ID reads rs1=9 → stall for every cycle until lo_wb_i(9). In the wb cycle sel1=3 and stall_o=0; the next cycle sb_pending_o[9]=0.
- WAW plus same-cycle set/clear: rd=9 pending, ID regwrite rd=9 → stall_o=1. Long issue to rd=4 in the same cycle as lo_wb_i(4), with 4 pending → bit 4 stays 1.
- Error/reset: lo_wb_i(12) with 12 not pending → err_o=1 sticky. Pulse rst mid-run → sb_pending_o=0, err_o=0, stall_cnt_o=0 asynchronously. Counter forced to saturate at 16'hFFFF and holds there.
